duty_meter: RTL
===============

DUTY_METER -- requirements
Module: duty_meter

Interface
REQ-001 Parameter CNT_W, default 16, width of high-time and period counters in clk cycles.
REQ-002 Parameter SYNC_STAGES, default 2, number of synchronizer flops on sig_in (minimum 2).
REQ-003 clk  input  1  clock; all logic on posedge clk.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 sig_in  input  1  measured periodic pulse (e.g. divided clock output); may be asynchronous to clk.
REQ-006 start  input  1  request one measurement; sampled only in IDLE.
REQ-007 busy  output  1  high in every state except IDLE.
REQ-008 valid  output  1  one-cycle pulse when results are updated.
REQ-009 high_cnt  output  CNT_W  clk cycles sig_in was high in the measured period.
REQ-010 period_cnt  output  CNT_W  clk cycles from rising edge to next rising edge.
REQ-011 timeout  output  1  last measurement aborted by counter saturation.
REQ-012 duty_pct  output  7  floor(high_cnt*100/period_cnt), 0..100.

Function
REQ-013 sig_in SHALL pass through SYNC_STAGES flops, then one delay flop; rise = sync & ~delay, fall = ~sync & delay.
REQ-014 FSM states: IDLE, WAIT_RISE, MEAS_HIGH, MEAS_LOW, DIV, DONE.
REQ-015 IDLE -> WAIT_RISE when start=1; this clears both internal counters and the internal timeout flag.
REQ-016 WAIT_RISE -> MEAS_HIGH on rise; high and period counters are loaded with 1 in that cycle.
REQ-017 MEAS_HIGH: both counters increment each cycle; on fall, go to MEAS_LOW, high counter frozen, period counter increments.
REQ-018 MEAS_LOW: period counter increments each cycle; on rise, go to DIV without incrementing (period = rise-to-rise distance).
REQ-019 Saturation: if any active counter equals 2^CNT_W-1 and would increment, hold it, set timeout, go to DONE; duty_pct = 0.
REQ-020 WAIT_RISE has no timeout; a stuck sig_in keeps the block busy until reset.
REQ-021 DIV: serial restoring division of high*100 by period, exactly CNT_W+7 cycles, then DONE.
REQ-022 DONE: high_cnt, period_cnt, timeout, duty_pct update; valid=1 for this cycle only; next state IDLE.
REQ-023 Result outputs SHALL hold their values between DONE cycles.
REQ-024 start while busy=1 SHALL be ignored; start in DONE cycle is ignored.
REQ-025 Simultaneous rise and saturation in the same cycle: saturation wins (timeout path).
REQ-026 high_cnt <= period_cnt SHALL hold for every non-timeout result.

Reset
REQ-027 rst low SHALL immediately force state IDLE, synchronizer/delay flops 0, counters 0.
REQ-028 Reset values: busy=0, valid=0, high_cnt=0, period_cnt=0, timeout=0, duty_pct=0.
REQ-029 Reset mid-measurement SHALL discard partial results; no valid pulse follows release.

Configuration
REQ-030 Macro DUTY_METER_PCT_EN defined: DIV state and divider SHALL be built; duty_pct per REQ-012.
REQ-031 Macro undefined: no divider, DIV skipped (MEAS_LOW rise -> DONE directly), duty_pct tied to 0; all other behaviour identical.

Verification
REQ-032 sig_in = 10-cycle, 6-high pulse synchronous to clk, start pulse -> valid once, high_cnt=6, period_cnt=10, duty_pct=60 (macro on) / 0 (off), timeout=0.
REQ-033 Latency: with macro, valid exactly CNT_W+8 cycles after the closing rise is detected (CNT_W+7 DIV + DONE); without, 1 cycle.
REQ-034 CNT_W=4, sig_in high 20 cycles -> timeout=1, high_cnt=15, duty_pct=0, valid once.
REQ-035 start pulsed again during MEAS_HIGH -> ignored; exactly one valid; second start after IDLE -> fresh correct result.
REQ-036 rst asserted during MEAS_LOW -> all outputs 0 immediately, busy=0, no valid after release.
REQ-037 sig_in 1-high/2-period (high_cnt=1, period_cnt=2) -> duty_pct=50; 49-high/50-period -> duty_pct=98.

Source files
------------

// File: rtl/duty_meter.sv
// duty_meter: measures high time, period and duty cycle of one sig_in period.
// Optional macro DUTY_METER_PCT_EN builds the serial divider behind duty_pct.
module duty_meter #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    input  logic             start,
    output logic             busy,
    output logic             valid,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] period_cnt,
    output logic             timeout,
    output logic [6:0]       duty_pct
);
    localparam logic [CNT_W-1:0] MAX = '1;
    typedef enum logic [2:0] {IDLE, WAIT_RISE, MEAS_HIGH, MEAS_LOW, DIV, DONE} state_t;
    state_t                 st_q, st_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   dly_q, dly_d;
    logic [CNT_W-1:0]       hi_q, hi_d, per_q, per_d;
    logic [CNT_W-1:0]       high_cnt_q, high_cnt_d, period_cnt_q, period_cnt_d;
    logic                   to_q, to_d, busy_q, busy_d, valid_q, valid_d, timeout_q, timeout_d;
    logic                   sync, rise, fall;
`ifdef DUTY_METER_PCT_EN
    localparam int NW = CNT_W + 7;
    localparam int DW = $clog2(NW);
    logic [NW-1:0]    quo_q, quo_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [CNT_W:0]   shf;
    logic             ge;
    logic [DW-1:0]    dcnt_q, dcnt_d;
    logic [6:0]       duty_q, duty_d;
`endif

    assign sync       = sync_q[SYNC_STAGES-1];
    assign rise       = sync & ~dly_q;
    assign fall       = ~sync & dly_q;
    assign busy       = busy_q;
    assign valid      = valid_q;
    assign high_cnt   = high_cnt_q;
    assign period_cnt = period_cnt_q;
    assign timeout    = timeout_q;
`ifdef DUTY_METER_PCT_EN
    assign duty_pct   = duty_q;
`else
    assign duty_pct   = 7'd0;
`endif

    // Next-state logic: edge detect, measurement FSM, counters, divider and result capture
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], sig_in};
        dly_d  = sync;
        st_d   = st_q;
        hi_d   = hi_q;
        per_d  = per_q;
        to_d   = to_q;
`ifdef DUTY_METER_PCT_EN
        quo_d  = quo_q;
        rem_d  = rem_q;
        dcnt_d = dcnt_q;
        shf    = {rem_q, quo_q[NW-1]};
        ge     = shf >= {1'b0, per_q};
`endif
        case (st_q)
            IDLE: if (start) begin
                st_d  = WAIT_RISE;
                hi_d  = '0;
                per_d = '0;
                to_d  = 1'b0;
            end
            WAIT_RISE: if (rise) begin
                st_d  = MEAS_HIGH;
                hi_d  = CNT_W'(1);
                per_d = CNT_W'(1);
            end
            // high_cnt never exceeds period_cnt, so the period counter saturates first
            MEAS_HIGH: if (per_q == MAX) begin
                to_d = 1'b1;
                st_d = DONE;
            end else begin
                per_d = per_q + CNT_W'(1);
                if (fall) st_d = MEAS_LOW;
                else hi_d = hi_q + CNT_W'(1);
            end
            // saturation is checked before rise so a coincident rise still times out
            MEAS_LOW: if (per_q == MAX) begin
                to_d = 1'b1;
                st_d = DONE;
            end else if (rise) begin
`ifdef DUTY_METER_PCT_EN
                st_d   = DIV;
                quo_d  = NW'(hi_q) * NW'(100);
                rem_d  = '0;
                dcnt_d = '0;
`else
                st_d   = DONE;
`endif
            end else begin
                per_d = per_q + CNT_W'(1);
            end
`ifdef DUTY_METER_PCT_EN
            // one restoring-division step per cycle, quotient shifts in from the right
            DIV: begin
                rem_d  = ge ? CNT_W'(shf - {1'b0, per_q}) : shf[CNT_W-1:0];
                quo_d  = {quo_q[NW-2:0], ge};
                dcnt_d = dcnt_q + DW'(1);
                if (dcnt_q == DW'(NW - 1)) st_d = DONE;
            end
`endif
            default: st_d = IDLE;
        endcase
        busy_d       = st_d != IDLE;
        valid_d      = st_d == DONE;
        high_cnt_d   = valid_d ? hi_d : high_cnt_q;
        period_cnt_d = valid_d ? per_d : period_cnt_q;
        timeout_d    = valid_d ? to_d : timeout_q;
`ifdef DUTY_METER_PCT_EN
        duty_d       = valid_d ? (to_d ? 7'd0 : quo_d[6:0]) : duty_q;
`endif
    end

    // FSM, synchronizer, counter and result registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_q         <= IDLE;
            sync_q       <= '0;
            dly_q        <= 1'b0;
            hi_q         <= '0;
            per_q        <= '0;
            to_q         <= 1'b0;
            busy_q       <= 1'b0;
            valid_q      <= 1'b0;
            high_cnt_q   <= '0;
            period_cnt_q <= '0;
            timeout_q    <= 1'b0;
        end else begin
            st_q         <= st_d;
            sync_q       <= sync_d;
            dly_q        <= dly_d;
            hi_q         <= hi_d;
            per_q        <= per_d;
            to_q         <= to_d;
            busy_q       <= busy_d;
            valid_q      <= valid_d;
            high_cnt_q   <= high_cnt_d;
            period_cnt_q <= period_cnt_d;
            timeout_q    <= timeout_d;
        end
    end

`ifdef DUTY_METER_PCT_EN
    // Divider state and duty result registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            quo_q  <= '0;
            rem_q  <= '0;
            dcnt_q <= '0;
            duty_q <= '0;
        end else begin
            quo_q  <= quo_d;
            rem_q  <= rem_d;
            dcnt_q <= dcnt_d;
            duty_q <= duty_d;
        end
    end
`endif
endmodule
